// File: rtl/dmem_if.sv
// Request/acknowledge bus between the CPU load/store unit and a data-memory responder.
// The CPU side drives the request fields; the responder drives completion and status.
interface dmem_if #(
    parameter int ADDR_W = 7
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, size, sign_ext, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, size, sign_ext, wdata,
        output ack, rdata, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Multicycle data-memory responder: latches a request, waits WAIT_CYC cycles, then performs a
// byte/half/word access with lane merging and load extension, flagging misaligned requests.
module dmem_responder #(
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 32,
    parameter int WAIT_CYC = 0
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              busy_next, ack_next, err_next;
    logic [31:0]       rdata_next;
    logic              latch, access, misaligned, mem_we;

    logic              l_we, l_sext;
    logic [ADDR_W-1:0] l_addr;
    logic [1:0]        l_size;
    logic [31:0]       l_wdata;

    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [31:0]       word, wlanes, load_val;
    logic [3:0]        be;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    // Word index wraps modulo DEPTH; wrap is never reported as an error.
    assign idx  = IDX_W'(32'(l_addr[ADDR_W-1:2]) % 32'(DEPTH));
    assign word = mem[idx];

    // Alignment check, store lane enables and load lane selection all use the latched request.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        wlanes     = l_wdata;
        sel_byte   = word[8*l_addr[1:0] +: 8];
        sel_half   = l_addr[1] ? word[31:16] : word[15:0];
        load_val   = word;
        case (l_size)
            2'b00: begin
                be       = 4'b0001 << l_addr[1:0];
                wlanes   = {4{l_wdata[7:0]}};
                load_val = {{24{l_sext & sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                misaligned = l_addr[0];
                be         = l_addr[1] ? 4'b1100 : 4'b0011;
                wlanes     = {2{l_wdata[15:0]}};
                load_val   = {{16{l_sext & sel_half[15]}}, sel_half};
            end
            2'b10: begin
                misaligned = |l_addr[1:0];
                be         = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_next  = bus.busy;
        ack_next   = 1'b0;
        err_next   = bus.err;
        rdata_next = bus.rdata;
        latch      = 1'b0;
        access     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    latch      = 1'b1;
                    cnt_next   = 4'(WAIT_CYC);
                    busy_next  = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    access     = 1'b1;
                    ack_next   = 1'b1;
                    err_next   = misaligned;
                    rdata_next = (misaligned || l_we) ? 32'd0 : load_val;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset at or before the access edge must suppress the write.
    assign mem_we = access && l_we && !misaligned && !rst;

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= 32'd0;
            bus.busy  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bus.ack   <= ack_next;
            bus.err   <= err_next;
            bus.rdata <= rdata_next;
            bus.busy  <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (latch && !rst) begin
            l_we    <= bus.we;
            l_addr  <= bus.addr;
            l_size  <= bus.size;
            l_sext  <= bus.sign_ext;
            l_wdata <= bus.wdata;
        end
    end

    // NOTE: the storage array has no reset; contents survive rst like a real RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) checked against a byte-array
// reference model with directed cases followed by random transactions.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] ref_mem [2][128];

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(7)) bus0 ();
    dmem_if #(.ADDR_W(7)) bus3 ();

    dmem_responder #(.ADDR_W(7), .DEPTH(32), .WAIT_CYC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.ADDR_W(7), .DEPTH(32), .WAIT_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit r, input bit w, input logic [6:0] a,
                         input logic [1:0] s, input bit sx, input logic [31:0] wd);
        if (d == 0) begin
            bus0.req = r; bus0.we = w; bus0.addr = a; bus0.size = s; bus0.sign_ext = sx; bus0.wdata = wd;
        end else begin
            bus3.req = r; bus3.we = w; bus3.addr = a; bus3.size = s; bus3.sign_ext = sx; bus3.wdata = wd;
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? bus0.ack : bus3.ack;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? bus0.busy : bus3.busy;
    endfunction

    // Reference: byte-addressed memory, alignment by address remainder, extension by arithmetic.
    task automatic model(input int d, input bit w, input logic [6:0] a, input logic [1:0] s,
                         input bit sx, input logic [31:0] wd,
                         output logic [31:0] exp_r, output logic exp_e);
        int n;
        int val;
        n     = 1 << s;
        exp_r = 32'd0;
        exp_e = 1'b0;
        if (s == 2'b11 || (int'(a) % n) != 0) begin
            exp_e = 1'b1;
        end else if (w) begin
            for (int k = 0; k < n; k++) ref_mem[d][int'(a) + k] = wd[8*k +: 8];
        end else begin
            val = 0;
            for (int k = 0; k < n; k++) val += int'(ref_mem[d][int'(a) + k]) << (8 * k);
            if (sx && n == 1 && val >= 128)   val -= 256;
            if (sx && n == 2 && val >= 32768) val -= 65536;
            exp_r = 32'(val);
        end
    endtask

    // One complete transaction; inputs are scrambled after accept to prove they are latched.
    task automatic txn(input int d, input bit w, input logic [6:0] a, input logic [1:0] s,
                       input bit sx, input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_r, rnd;
        logic        exp_e, seen, got_e;
        int          lat;
        model(d, w, a, s, sx, wd, exp_r, exp_e);
        drive(d, 1'b1, w, a, s, sx, wd);
        @(posedge clk);
        #1;
        check("busy_after_accept", 32'(get_busy(d)), 32'd1);
        rnd = $urandom;
        drive(d, 1'b1, rnd[0], rnd[7:1], rnd[9:8], rnd[10], $urandom);
        seen = 1'b0;
        lat  = 0;
        got  = 32'd0;
        got_e = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (get_ack(d)) begin
                seen  = 1'b1;
                lat   = i;
                got   = (d == 0) ? bus0.rdata : bus3.rdata;
                got_e = (d == 0) ? bus0.err : bus3.err;
            end else begin
                check("busy_while_wait", 32'(get_busy(d)), 32'd1);
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
            check("busy_with_ack", 32'(get_busy(d)), 32'd1);
            check("rdata", got, exp_r);
            check("err", 32'(got_e), 32'(exp_e));
        end
        drive(d, 1'b0, 1'b0, 7'd0, 2'b00, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        check("ack_one_cycle", 32'(get_ack(d)), 32'd0);
        check("busy_released", 32'(get_busy(d)), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] got, rnd;
        drive(0, 1'b0, 1'b0, 7'd0, 2'b00, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 7'd0, 2'b00, 1'b0, 32'd0);

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack0", 32'(bus0.ack), 32'd0);
        check("rst_err0", 32'(bus0.err), 32'd0);
        check("rst_busy0", 32'(bus0.busy), 32'd0);
        check("rst_rdata0", bus0.rdata, 32'd0);
        check("rst_ack3", 32'(bus3.ack), 32'd0);
        check("rst_busy3", 32'(bus3.busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy0", 32'(bus0.busy), 32'd0);
        check("idle_busy3", 32'(bus3.busy), 32'd0);

        // Fill both memories with known random words
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++)
                txn(d, 1'b1, 7'(w * 4), 2'b10, 1'b0, $urandom, got);

        // Word store then load
        txn(0, 1'b1, 7'h08, 2'b10, 1'b0, 32'hDEADBEEF, got);
        check("store_rdata_zero", got, 32'd0);
        txn(0, 1'b0, 7'h08, 2'b10, 1'b0, 32'd0, got);
        check("word_load", got, 32'hDEADBEEF);

        // Byte merge and extension
        txn(0, 1'b1, 7'h10, 2'b10, 1'b0, 32'h11223344, got);
        txn(0, 1'b1, 7'h12, 2'b00, 1'b0, 32'hFFFFFF80, got);
        txn(0, 1'b0, 7'h10, 2'b10, 1'b0, 32'd0, got);
        check("byte_merge", got, 32'h11803344);
        txn(0, 1'b0, 7'h12, 2'b00, 1'b1, 32'd0, got);
        check("byte_sext", got, 32'hFFFFFF80);
        txn(0, 1'b0, 7'h12, 2'b00, 1'b0, 32'd0, got);
        check("byte_zext", got, 32'h00000080);

        // Halfword store into upper half, load with sign extension
        txn(0, 1'b1, 7'h14, 2'b10, 1'b0, 32'h01020304, got);
        txn(0, 1'b1, 7'h16, 2'b01, 1'b0, 32'h0000ABCD, got);
        txn(0, 1'b0, 7'h14, 2'b10, 1'b0, 32'd0, got);
        check("half_merge", got, 32'hABCD0304);
        txn(0, 1'b0, 7'h16, 2'b01, 1'b1, 32'd0, got);
        check("half_sext", got, 32'hFFFFABCD);

        // Misaligned and illegal accesses leave memory untouched
        txn(0, 1'b0, 7'h0A, 2'b10, 1'b0, 32'd0, got);
        txn(0, 1'b1, 7'h05, 2'b01, 1'b0, 32'h00001234, got);
        txn(0, 1'b1, 7'h04, 2'b11, 1'b0, 32'h55555555, got);
        txn(0, 1'b0, 7'h04, 2'b10, 1'b0, 32'd0, got);

        // Wait states
        txn(1, 1'b1, 7'h40, 2'b10, 1'b0, 32'hCAFEF00D, got);
        txn(1, 1'b0, 7'h40, 2'b10, 1'b0, 32'd0, got);
        check("wait_word_load", got, 32'hCAFEF00D);

        // Reset two cycles after accepting a store: no ack, no write
        drive(1, 1'b1, 1'b1, 7'h20, 2'b10, 1'b0, 32'h5A5A5A5A);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 7'd0, 2'b00, 1'b0, 32'd0);
        check("rst_mid_busy", 32'(bus3.busy), 32'd1);
        @(posedge clk);
        #1;
        check("rst_mid_ack_a", 32'(bus3.ack), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_ack_b", 32'(bus3.ack), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ack_c", 32'(bus3.ack), 32'd0);
        check("rst_mid_busy_c", 32'(bus3.busy), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_ack_d", 32'(bus3.ack), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ack_e", 32'(bus3.ack), 32'd0);
        check("rst_mid_busy_e", 32'(bus3.busy), 32'd0);
        txn(1, 1'b0, 7'h20, 2'b10, 1'b0, 32'd0, got);

        // Random traffic on both responders
        for (int i = 0; i < 200; i++) begin
            rnd = $urandom;
            txn(i % 2, rnd[0], rnd[7:1], rnd[9:8], rnd[10], $urandom, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
